// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle for the register slave: AW, W, B, AR and R channels.
interface axi4_lite_reg_slave_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned ADDR_WIDTH = (DATA_WIDTH == 32) ? 32 : 64;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic [2:0]            awprot;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic [2:0]            arprot;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, arprot, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, arprot, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS byte-strobed read/write registers.
// AW and W are buffered independently; the write commits once both are held.
module axi4_lite_reg_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  axi4_lite_reg_slave_if.slave           bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);
  localparam int unsigned ADDR_WIDTH = (DATA_WIDTH == 32) ? 32 : 64;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFS        = $clog2(STRB_WIDTH);
  localparam int unsigned IDX        = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("axi4_lite_reg_slave: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
    $error("axi4_lite_reg_slave: NUM_REGS must be a power of two >= 2");
  end

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [IDX-1:0] widx;
  logic [IDX-1:0] ridx;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (OFS + IDX)) == '0;
  endfunction

  assign widx = aw_addr_q[OFS+IDX-1:OFS];
  assign ridx = bus.araddr[OFS+IDX-1:OFS];

  assign bus.awready = !aw_full && !bvalid_q;
  assign bus.wready  = !w_full && !bvalid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = !rvalid_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.awprot, bus.arprot, aw_addr_q[OFS-1:0], bus.araddr[OFS-1:0]};

  // Write path: buffer AW/W, commit when both held, then present B until accepted.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (bvalid_q && bus.bready) bvalid_q <= 1'b0;
      if (aw_full && w_full) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        if (in_range(aw_addr_q)) begin
          bresp_q <= RESP_OKAY;
          for (int unsigned k = 0; k < STRB_WIDTH; k++)
            if (w_strb_q[k]) regs[widx][k*8 +: 8] <= w_data_q[k*8 +: 8];
        end else begin
          bresp_q <= RESP_SLVERR;
        end
      end else begin
        if (bus.awvalid && bus.awready) begin
          aw_full   <= 1'b1;
          aw_addr_q <= bus.awaddr;
        end
        if (bus.wvalid && bus.wready) begin
          w_full   <= 1'b1;
          w_data_q <= bus.wdata;
          w_strb_q <= bus.wstrb;
        end
      end
    end
  end

  // Read path: capture register on AR handshake, hold R until accepted.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (bus.arvalid && bus.arready) begin
      rvalid_q <= 1'b1;
      if (in_range(bus.araddr)) begin
        rdata_q <= regs[ridx];
        rresp_q <= RESP_OKAY;
      end else begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end
    end else if (rvalid_q && bus.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Flatten the register file onto the observation port.
  always_comb begin
    regs_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      regs_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave with scoreboarded B and R responses.
module tb_axi4_lite_reg_slave;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] regs_q;

  axi4_lite_reg_slave_if #(.DATA_WIDTH(32)) bus ();

  axi4_lite_reg_slave #(.DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .aclk   (clk),
    .areset (rst),
    .bus    (bus),
    .regs_q (regs_q)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdl [16];
  logic [1:0]  bq [$];
  rexp_t       rq [$];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] flat_model();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = mdl[i];
    return f;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    if (addr[31:6] != 0) return SLVERR;
    for (int k = 0; k < 4; k++)
      if (strb[k]) mdl[addr[5:2]][k*8 +: 8] = data[k*8 +: 8];
    return OKAY;
  endfunction

  function automatic rexp_t model_read(input logic [31:0] addr);
    rexp_t e;
    if (addr[31:6] != 0) begin
      e.d = '0;
      e.r = SLVERR;
    end else begin
      e.d = mdl[addr[5:2]];
      e.r = OKAY;
    end
    return e;
  endfunction

  // Wait for B, hold it for 'hold' cycles checking stability, then accept it.
  task automatic wait_b(input int exp_lat, input int hold);
    int lat;
    logic [1:0] e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.bvalid && lat < 10);
    check("b_latency", lat, exp_lat);
    check("b_sb_nonempty", bq.size() > 0, 1);
    e = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
    check("bresp", bus.bresp, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bvalid_hold", bus.bvalid, 1);
      check("bresp_hold", bus.bresp, e);
      check("awready_stall", bus.awready, 0);
      check("wready_stall", bus.wready, 0);
    end
    bus.bready = 1'b1;
    @(posedge clk);
    #1 bus.bready = 1'b0;
    @(negedge clk);
    check("bvalid_clear", bus.bvalid, 0);
  endtask

  // R must appear one cycle after the AR handshake; hold it, then accept.
  task automatic wait_r(input int hold);
    rexp_t e;
    @(negedge clk);
    check("rvalid_latency", bus.rvalid, 1);
    check("r_sb_nonempty", rq.size() > 0, 1);
    e = (rq.size() > 0) ? rq.pop_front() : 'x;
    check("rdata", bus.rdata, e.d);
    check("rresp", bus.rresp, e.r);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_hold", bus.rvalid, 1);
      check("rdata_hold", bus.rdata, e.d);
      check("rresp_hold", bus.rresp, e.r);
      check("arready_stall", bus.arready, 0);
    end
    bus.rready = 1'b1;
    @(posedge clk);
    #1 bus.rready = 1'b0;
    @(negedge clk);
    check("rvalid_clear", bus.rvalid, 0);
  endtask

  // w_lead = cycles W is handshaken ahead of AW (0 = same cycle).
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int hold);
    bq.push_back(model_write(addr, data, strb));
    @(negedge clk);
    check("wready_idle", bus.wready, 1);
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    if (w_lead == 0) begin
      check("awready_idle", bus.awready, 1);
      bus.awaddr  = addr;
      bus.awvalid = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.wvalid = 1'b0;
    bus.awvalid = 1'b0;
    if (w_lead > 0) begin
      for (int i = 0; i < w_lead; i++) begin
        @(negedge clk);
        check("wready_w_full", bus.wready, 0);
        check("bvalid_early", bus.bvalid, 0);
      end
      check("awready_w_held", bus.awready, 1);
      bus.awaddr  = addr;
      bus.awvalid = 1'b1;
      @(posedge clk);
      #1 bus.awvalid = 1'b0;
    end
    wait_b(2, hold);
  endtask

  task automatic read_txn(input logic [31:0] addr, input int hold);
    rq.push_back(model_read(addr));
    @(negedge clk);
    check("arready_idle", bus.arready, 1);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    wait_r(hold);
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 0; bus.awprot = '0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
    bus.araddr = '0; bus.arvalid = 0; bus.arprot = '0; bus.rready = 0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_awready", bus.awready, 1);
    check("rst_wready", bus.wready, 1);
    check("rst_arready", bus.arready, 1);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_regs", regs_q, 0);

    // Basic same-cycle write and readback.
    write_txn(32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    read_txn(32'h04, 0);

    // W well ahead of AW, partial strobes.
    write_txn(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0);
    write_txn(32'h08, 32'h1234ABCD, 4'h3, 3, 0);
    check("reg2_partial", regs_q[2*32 +: 32], 32'hFFFFABCD);
    read_txn(32'h08, 0);

    // Out-of-range write and read.
    write_txn(32'h40, 32'hCAFEF00D, 4'hF, 0, 0);
    check("oor_no_change", regs_q, flat_model());
    read_txn(32'h40, 0);

    // Back-pressure on B and R.
    write_txn(32'h0C, 32'hA5A5_5A5A, 4'hF, 0, 5);
    read_txn(32'h0C, 5);
    write_txn(32'h3C, 32'h0BAD_0BAD, 4'hC, 0, 0);
    check("regs_all", regs_q, flat_model());

    // Read of reg 3 handshaken on the edge that commits a write to reg 3.
    rq.push_back(model_read(32'h0C));
    bq.push_back(model_write(32'h0C, 32'h55AA_1234, 4'hF));
    @(negedge clk);
    bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
    bus.wdata = 32'h55AA_1234; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk);
    #1 begin bus.awvalid = 1'b0; bus.wvalid = 1'b0; end
    @(negedge clk);
    check("arready_concurrent", bus.arready, 1);
    bus.araddr = 32'h0C; bus.arvalid = 1'b1;
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    wait_r(0);
    wait_b(1, 0);
    read_txn(32'h0C, 0);

    // Reset with AW buffered and R pending.
    @(negedge clk);
    bus.awaddr = 32'h10; bus.awvalid = 1'b1;
    bus.araddr = 32'h04; bus.arvalid = 1'b1;
    @(posedge clk);
    #1 begin bus.awvalid = 1'b0; bus.arvalid = 1'b0; end
    @(negedge clk);
    check("pre_rst_rvalid", bus.rvalid, 1);
    check("pre_rst_aw_full", bus.awready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    @(negedge clk);
    check("mid_rst_rvalid", bus.rvalid, 0);
    check("mid_rst_rdata", bus.rdata, 0);
    check("mid_rst_rresp", bus.rresp, 0);
    check("mid_rst_bvalid", bus.bvalid, 0);
    check("mid_rst_bresp", bus.bresp, 0);
    check("mid_rst_awready", bus.awready, 1);
    check("mid_rst_wready", bus.wready, 1);
    check("mid_rst_arready", bus.arready, 1);
    check("mid_rst_regs", regs_q, flat_model());
    // A lone W must not pair with the discarded AW.
    bus.wdata = 32'h1111_2222; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk);
    #1 bus.wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_bvalid", bus.bvalid, 0);
    end
    check("post_rst_regs", regs_q, 0);

    check("bq_drained", bq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi4_lite_reg_slave.md
AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: DATA_WIDTH, 32, data bus width; the only legal values SHALL be 32 and 64.
REQ-003 Parameter: NUM_REGS, 16, number of read/write registers; it SHALL be a power of two, minimum 2.
REQ-004 Derived: ADDR_WIDTH = 32 when DATA_WIDTH = 32, else 64; STRB_WIDTH = DATA_WIDTH/8; OFS = log2(STRB_WIDTH); IDX = log2(NUM_REGS).
REQ-005 Port list, one per line (name, direction, width, meaning):
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous active-high reset
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awprot  in  3  write protection; ignored
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  STRB_WIDTH  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arprot  in  3  read protection; ignored
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
regs_q  out  NUM_REGS*DATA_WIDTH  register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]

Function
REQ-006 Register index SHALL be addr[OFS+IDX-1:OFS]; addr[OFS-1:0] ignored; address in range iff addr[ADDR_WIDTH-1:OFS+IDX] == 0.
REQ-007 Write channel: AW and W SHALL be accepted independently, each into a one-entry holding buffer (aw_full, w_full).
REQ-008 awready SHALL equal !aw_full && !bvalid; wready SHALL equal !w_full && !bvalid.
REQ-009 When aw_full and w_full are both set at an edge, that edge SHALL commit the write, clear both flags, set bvalid; same-cycle AW+W handshakes at edge N give commit and bvalid at edge N+1.
REQ-010 Commit, in range: byte k of the indexed register SHALL update iff wstrb[k]; bresp = 2'b00 (OKAY).
REQ-011 Commit, out of range: no register SHALL change; bresp = 2'b10 (SLVERR).
REQ-012 bvalid and bresp SHALL hold stable until the edge where bvalid && bready, which clears bvalid; no new AW/W accepted while bvalid is high.
REQ-013 Read channel: arready SHALL equal !rvalid.
REQ-014 On AR handshake at edge N, rdata, rresp, rvalid SHALL be registered at edge N (one-cycle latency); in range: rdata = register value before any write committing at edge N, rresp = OKAY; out of range: rdata = 0, rresp = SLVERR.
REQ-015 rvalid, rdata, rresp SHALL hold stable until the edge where rvalid && rready.
REQ-016 Read and write paths SHALL operate concurrently with no mutual stalling.
REQ-017 VALID inputs SHALL be sampled only with the matching READY; a VALID that drops before handshake SHALL have no effect.

Reset
REQ-018 With areset high at an edge: all registers = 0, aw_full = w_full = 0, bvalid = rvalid = 0, bresp = rresp = 2'b00, rdata = 0; awready, wready, arready = 1 from the following cycle.
REQ-019 Reset mid-transaction SHALL discard buffered AW/W and pending B/R responses without committing them.

Verification
REQ-020 Write 0xDEADBEEF to 0x04, wstrb 0xF, AW+W same cycle -> bvalid next cycle, bresp 00; read 0x04 -> rdata 0xDEADBEEF, rresp 00.
REQ-021 W three cycles before AW to 0x08, wstrb 0x3, data 0x1234ABCD over 0xFFFFFFFF -> reg 2 = 0xFFFFABCD.
REQ-022 Write to 0x40 (NUM_REGS=16) -> bresp 10, no register changes; read 0x40 -> rdata 0, rresp 10.
REQ-023 bready low 5 cycles -> bvalid/bresp stable, awready = wready = 0 throughout; same for rready/rvalid/arready.
REQ-024 Read and write reg 3 handshaking on same edge -> rdata = old value; subsequent read returns new value.
REQ-025 areset asserted with aw_full set and rvalid high -> all outputs at reset values, registers 0, no later bvalid.
